// File: rtl/wide_uart_arb_pkg.sv
// Shared types for the wide_uart command/response arbiter.
package wide_uart_arb_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  int idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/wide_uart_arbiter.sv
// Round-robin sharing of one wide_uart command/response link, one transaction in flight.
// Optional response timeout is compiled in with WIDE_UART_ARB_TIMEOUT_EN.
module wide_uart_arbiter
  import wide_uart_arb_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000,
  localparam int         IW             = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ*64-1:0]   req_tdata,
  input  logic [N_REQ-1:0]      req_tvalid,
  output logic [N_REQ-1:0]      req_tready,
  output logic [DATA_W-1:0]     rsp_tdata,
  output logic                  rsp_tuser,
  output logic [N_REQ-1:0]      rsp_tvalid,
  input  logic [N_REQ-1:0]      rsp_tready,
  output logic [DATA_W-1:0]     u_tx_tdata,
  output logic                  u_tx_tvalid,
  input  logic                  u_tx_tready,
  input  logic [DATA_W-1:0]     u_rx_tdata,
  input  logic                  u_rx_tvalid,
  output logic                  u_rx_tready,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  stray,
  output logic [1:0]            fsm_state
);

  // Every stream moves a word on a cycle where valid and ready are both high;
  // valid never waits on ready, and data is held while valid is up and ready is low.

  arb_state_t        state, state_nx;
  logic [IW-1:0]     ptr;
  logic [DATA_W-1:0] cmd_buf, rsp_buf;
  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     gnt_id;
  logic              any;
  logic              timeout_hit;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (req_tvalid),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign busy       = (state != IDLE);
  assign fsm_state  = state;
  assign u_tx_tdata = cmd_buf;
  assign rsp_tdata  = rsp_buf;

  always_comb begin
    state_nx    = state;
    req_tready  = '0;
    u_tx_tvalid = 1'b0;
    u_rx_tready = 1'b0;
    rsp_tvalid  = '0;
    stray       = 1'b0;
    case (state)
      IDLE: begin
        // Nothing is outstanding, so any RX word here is unsolicited and discarded.
        u_rx_tready = 1'b1;
        stray       = u_rx_tvalid;
        if (any) begin
          req_tready = gnt;
          state_nx   = SEND;
        end
      end
      SEND: begin
        u_tx_tvalid = 1'b1;
        if (u_tx_tready) state_nx = WAIT;
      end
      WAIT: begin
        u_rx_tready = 1'b1;
        if (u_rx_tvalid || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        rsp_tvalid[grant_id] = 1'b1;
        if (rsp_tready[grant_id]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cmd_buf  <= '0;
      rsp_buf  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any) begin
          cmd_buf  <= req_tdata[gnt_id*DATA_W +: DATA_W];
          grant_id <= gnt_id;
        end
        WAIT: begin
          if (u_rx_tvalid)      rsp_buf <= u_rx_tdata;
          else if (timeout_hit) rsp_buf <= '0;
        end
        RESP: if (rsp_tready[grant_id]) begin
          ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef WIDE_UART_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        err;

  assign timeout_hit = (state == WAIT) && (to_cnt == TIMEOUT_CYCLES - 32'd1);
  assign rsp_tuser   = err;

  // An RX word in the final wait cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == SEND && u_tx_tready) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        if (u_rx_tvalid) begin
          err <= 1'b0;
        end else if (timeout_hit) begin
          err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign rsp_tuser      = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wide_uart_arbiter.sv
// Directed + randomized bench for wide_uart_arbiter against a transaction-level model.
// Timeout scenario runs only when WIDE_UART_ARB_TIMEOUT_EN is defined.
module tb_wide_uart_arbiter;

  localparam int          N  = 4;
  localparam logic [31:0] TO = 32'd16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*64-1:0] req_tdata;
  logic [N-1:0]    req_tvalid, req_tready;
  logic [63:0]     rsp_tdata;
  logic            rsp_tuser;
  logic [N-1:0]    rsp_tvalid, rsp_tready;
  logic [63:0]     u_tx_tdata;
  logic            u_tx_tvalid, u_tx_tready;
  logic [63:0]     u_rx_tdata;
  logic            u_rx_tvalid, u_rx_tready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            stray;
  logic [1:0]      fsm_state;

  int          total = 0;
  int          bad   = 0;
  int          m_ptr = 0;
  int          g;
  logic [63:0] req_data [N];

  always #5 clk = ~clk;

  wide_uart_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_tdata   (req_tdata),
    .req_tvalid  (req_tvalid),
    .req_tready  (req_tready),
    .rsp_tdata   (rsp_tdata),
    .rsp_tuser   (rsp_tuser),
    .rsp_tvalid  (rsp_tvalid),
    .rsp_tready  (rsp_tready),
    .u_tx_tdata  (u_tx_tdata),
    .u_tx_tvalid (u_tx_tvalid),
    .u_tx_tready (u_tx_tready),
    .u_rx_tdata  (u_rx_tdata),
    .u_rx_tvalid (u_rx_tvalid),
    .u_rx_tready (u_rx_tready),
    .busy        (busy),
    .grant_id    (grant_id),
    .stray       (stray),
    .fsm_state   (fsm_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_req();
    for (int i = 0; i < N; i++) req_tdata[i*64 +: 64] = req_data[i];
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
    pack_req();
  endtask

  // Reference: grant goes to the first valid requester at or after the
  // position following the last completed grant, wrapping around.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic run_txn(input logic [N-1:0] valids, input logic [63:0] rsp_word,
                         input bit early, input int tx_delay, input int rsp_delay,
                         input int hold, output int gout);
    int          exp_g;
    logic [63:0] exp_cmd;
    logic [N-1:0] onehot, others;
    exp_g   = model_pick(valids);
    exp_cmd = req_data[exp_g];
    onehot  = '0;
    onehot[exp_g] = 1'b1;
    pack_req();
    req_tvalid = valids;
    #1;
    chk("idle_req_tready", 64'(req_tready), 64'(onehot));
    chk("idle_busy", 64'(busy), 64'd0);
    cyc();
    req_tvalid[exp_g] = 1'b0;
    if (early) begin
      u_rx_tvalid = 1'b1;
      u_rx_tdata  = rsp_word;
    end
    for (int c = 0; c <= tx_delay; c++) begin
      #1;
      chk("send_grant_id", 64'(grant_id), 64'(exp_g));
      chk("send_req_tready", 64'(req_tready), 64'd0);
      chk("send_tx_valid", 64'(u_tx_tvalid), 64'd1);
      chk("send_tx_data", u_tx_tdata, exp_cmd);
      chk("send_rx_ready", 64'(u_rx_tready), 64'd0);
      if (c == tx_delay) u_tx_tready = 1'b1;
      cyc();
      u_tx_tready = 1'b0;
    end
    #1;
    chk("wait_tx_valid", 64'(u_tx_tvalid), 64'd0);
    chk("wait_rx_ready", 64'(u_rx_tready), 64'd1);
    chk("wait_rsp_valid", 64'(rsp_tvalid), 64'd0);
    if (!early) begin
      for (int c = 0; c < rsp_delay; c++) begin
        cyc();
        #1;
        chk("wait_hold_rsp_valid", 64'(rsp_tvalid), 64'd0);
        chk("wait_hold_busy", 64'(busy), 64'd1);
      end
      u_rx_tvalid = 1'b1;
      u_rx_tdata  = rsp_word;
    end
    cyc();
    if (hold > 0) begin
      u_rx_tvalid = 1'b1;
      u_rx_tdata  = {$urandom, $urandom};
    end else begin
      u_rx_tvalid = 1'b0;
    end
    for (int c = 0; c <= hold; c++) begin
      #1;
      chk("resp_valid", 64'(rsp_tvalid), 64'(onehot));
      chk("resp_data", rsp_tdata, rsp_word);
      chk("resp_user", 64'(rsp_tuser), 64'd0);
      chk("resp_rx_ready", 64'(u_rx_tready), 64'd0);
      if (c == hold) begin
        rsp_tready  = onehot;
        u_rx_tvalid = 1'b0;
      end else begin
        others     = N'($urandom);
        rsp_tready = others & ~onehot;
      end
      cyc();
    end
    rsp_tready = '0;
    #1;
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_rsp_valid", 64'(rsp_tvalid), 64'd0);
    m_ptr = (exp_g + 1) % N;
    gout  = exp_g;
  endtask

  initial begin
    rst         = 1'b0;
    req_tvalid  = '0;
    rsp_tready  = '0;
    u_tx_tready = 1'b0;
    u_rx_tvalid = 1'b0;
    u_rx_tdata  = '0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    pack_req();

    // Reset state
    repeat (3) cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_tvalid), 64'd0);
    chk("rst_rsp_data", rsp_tdata, 64'd0);
    chk("rst_rsp_user", 64'(rsp_tuser), 64'd0);
    chk("rst_tx_valid", 64'(u_tx_tvalid), 64'd0);
    chk("rst_tx_data", u_tx_tdata, 64'd0);
    chk("rst_req_tready", 64'(req_tready), 64'd0);
    chk("rst_rx_ready", 64'(u_rx_tready), 64'd1);
    chk("rst_stray", 64'(stray), 64'd0);
    #2 rst = 1'b1;
    cyc();

    // Fairness: all requesters continuously valid
    for (int i = 0; i < 8; i++) begin
      randomize_data();
      run_txn(4'hF, {$urandom, $urandom}, 1'b0, $urandom_range(0, 2),
              $urandom_range(0, 4), 0, g);
      chk("rr_order", 64'(g), 64'(i % N));
    end
    req_tvalid = '0;

    // Directed: requester 2 with a known command and response
    randomize_data();
    req_data[2] = 64'h0123_4567_89AB_CDEF;
    run_txn(4'b0100, 64'hDEAD_BEEF_0000_0001, 1'b0, 2, 3, 0, g);
    chk("directed_grant", 64'(g), 64'd2);
    req_tvalid = '0;

    // Asynchronous reset while waiting for a response (pointer sits at 3)
    randomize_data();
    req_tvalid = 4'b0100;
    cyc();
    req_tvalid  = '0;
    u_tx_tready = 1'b1;
    cyc();
    u_tx_tready = 1'b0;
    cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant_id", 64'(grant_id), 64'd0);
    chk("arst_rx_ready", 64'(u_rx_tready), 64'd1);
    chk("arst_tx_valid", 64'(u_tx_tvalid), 64'd0);
    #2 rst = 1'b1;
    m_ptr = 0;
    cyc();
    randomize_data();
    run_txn(4'b1010, {$urandom, $urandom}, 1'b0, 1, 2, 1, g);
    chk("arst_next_grant", 64'(g), 64'd1);
    req_tvalid = '0;

    // Randomized transactions
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      run_txn(N'($urandom_range(1, 15)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3), g);
      req_tvalid = '0;
    end

    // Backpressure: early RX word during SEND, response held 10 cycles
    randomize_data();
    run_txn(4'b0001, {$urandom, $urandom}, 1'b1, 3, 0, 10, g);
    req_tvalid = '0;

`ifdef WIDE_UART_ARB_TIMEOUT_EN
    // Timeout: no RX word, RESP reached 16 cycles after WAIT entry
    randomize_data();
    req_tvalid = 4'b1000;
    #1;
    chk("to_req_tready", 64'(req_tready), 64'(model_pick(4'b1000) == 3 ? 4'b1000 : 4'b0000));
    cyc();
    req_tvalid  = '0;
    u_tx_tready = 1'b1;
    cyc();
    u_tx_tready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("to_wait_rsp_valid", 64'(rsp_tvalid), 64'd0);
      cyc();
    end
    #1;
    chk("to_rsp_valid", 64'(rsp_tvalid), 64'(4'b1000));
    chk("to_rsp_user", 64'(rsp_tuser), 64'd1);
    chk("to_rsp_data", rsp_tdata, 64'd0);
    rsp_tready = 4'b1000;
    cyc();
    rsp_tready = '0;
    m_ptr = 0;
`endif

    // Late / unsolicited RX word in IDLE is dropped with a stray pulse
    u_rx_tvalid = 1'b1;
    u_rx_tdata  = {$urandom, $urandom};
    #1;
    chk("stray_pulse", 64'(stray), 64'd1);
    chk("stray_rx_ready", 64'(u_rx_tready), 64'd1);
    chk("stray_rsp_valid", 64'(rsp_tvalid), 64'd0);
    cyc();
    u_rx_tvalid = 1'b0;
    #1;
    chk("stray_clear", 64'(stray), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_no_rsp", 64'(rsp_tvalid), 64'd0);

    // Post-stray transaction still follows round-robin order
    randomize_data();
    run_txn(4'hF, {$urandom, $urandom}, 1'b0, 0, 0, 0, g);
    req_tvalid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_uart_arbiter.md
# wide_uart_arbiter

Shares one `wide_uart` 64-bit command/response link among `N_REQ` requesters. Each requester's 64-bit command word is round-robin granted and forwarded to the UART TX stream, and the block then waits for exactly one 64-bit response word. That response, or a timeout error, is routed back to the granted requester. The block sits between the on-chip command masters and `wide_uart`, with one transaction outstanding at a time.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 32'd2_000_000 — response wait limit in clk cycles; must be ≥ 2.
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-low reset.
- `req_tdata` in N_REQ*64 — command words; requester i occupies bits [i*64 +: 64].
- `req_tvalid` in N_REQ — command valid, per requester.
- `req_tready` out N_REQ — command accepted, per requester.
- `rsp_tdata` out 64 — response word, shared by all requesters.
- `rsp_tuser` out 1 — 1 = timeout error (data is 0).
- `rsp_tvalid` out N_REQ — response valid; one-hot to the granted requester.
- `rsp_tready` in N_REQ — response accept, per requester.
- `u_tx_tdata` out 64 — to `wide_uart` s_axis_tdata.
- `u_tx_tvalid` out 1 — to `wide_uart` s_axis_tvalid.
- `u_tx_tready` in 1 — from `wide_uart` s_axis_tready.
- `u_rx_tdata` in 64 — from `wide_uart` m_axis_tdata.
- `u_rx_tvalid` in 1 — from `wide_uart` m_axis_tvalid.
- `u_rx_tready` out 1 — to `wide_uart` m_axis_tready.
- `busy` out 1 — high whenever state ≠ IDLE.
- `grant_id` out $clog2(N_REQ) — index of the current or most recent grant.
- `stray` out 1 — one-cycle pulse when an unsolicited RX word is dropped.

## Operation
- State machine with states IDLE, SEND, WAIT, RESP.
- **IDLE**
  - Choose the first requester with `req_tvalid` set, searching from `ptr` upward with wrap.
  - Drive `req_tready[g]`=1 combinationally for that requester only.
  - Capture its data into `cmd_buf` and set `grant_id`=g. Next state is SEND.
  - `u_rx_tready`=1. Any `u_rx_tvalid` word here is dropped and `stray` pulses.
- **SEND**
  - `u_tx_tvalid`=1, `u_tx_tdata`=`cmd_buf`.
  - On `u_tx_tready`, go to WAIT and clear the timeout counter.
- **WAIT**
  - `u_rx_tready`=1.
  - On `u_rx_tvalid`: `rsp_buf`=`u_rx_tdata`, err=0, go to RESP.
  - Timeout (when compiled in): the counter increments each cycle. On reaching `TIMEOUT_CYCLES`-1 with no RX word: `rsp_buf`=0, err=1, go to RESP. An RX word in the same cycle wins over the timeout.
- **RESP**
  - `rsp_tvalid[grant_id]`=1; `rsp_tdata`=`rsp_buf`; `rsp_tuser`=err.
  - On `rsp_tready[grant_id]`: `ptr`=(grant_id+1) mod N_REQ, go to IDLE.
  - `rsp_tready` from other requesters is ignored.
- `u_rx_tready`=0 in SEND and RESP, so wide_uart holds any early word (backpressure).
- A response arriving after a timeout reaches IDLE and is dropped with a `stray` pulse.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `grant_id`=0, buffers 0, err 0.
  - All outputs 0, except `req_tready`/`u_rx_tready`, which follow IDLE's combinational rules.
- Reset is asynchronous mid-transaction: everything returns to IDLE immediately. wide_uart is not reset by this block.
- Minimum turnaround: accept (IDLE) → SEND +1 cycle → WAIT +1 → RESP +1 → IDLE +1. One transaction takes at least 4 cycles plus UART time.
- AXIS rules:
  - Outputs are held stable while valid and not ready.
  - `rsp_tvalid` never deasserts without a handshake.
  - The block never depends on `*_tready` before asserting valid.
- Requests arriving during busy are held off (`req_tready`=0); no request is lost.
- Round-robin fairness: with all requesters continuously valid, the grant order is 0,1,…,N_REQ-1,0…

## Configuration
- `WIDE_UART_ARB_TIMEOUT_EN` defined: timeout counter (32-bit) present; WAIT exits on timeout with error as above.
- Undefined: no counter; WAIT exits only on an RX word; `rsp_tuser` is tied 0.

## Structure
- Package `wide_uart_arb_pkg`:
  - state enum `arb_state_t` {IDLE, SEND, WAIT, RESP}.
  - `localparam` data width 64.
- Sub-module `rr_arbiter`:
  - Combinational pick over a `req` vector and `ptr`.
  - Outputs: one-hot `gnt`, index `gnt_id`, `any`.
  - Parameter `N`.

## Test plan
- Requester 2 sends 64'h0123_4567_89AB_CDEF; the UART model echoes 64'hDEAD_BEEF_0000_0001 → `u_tx_tdata` matches; `rsp_tvalid`=4'b0100, data 64'hDEAD_BEEF_0000_0001, `rsp_tuser`=0.
- All 4 requesters continuously valid for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Timeout, with `TIMEOUT_CYCLES`=16 and macro defined, no RX word:
  - RESP is entered 16 cycles after entering WAIT, with `rsp_tuser`=1 and data 0.
  - An RX word injected later produces a `stray` pulse and no `rsp_tvalid`.
- `rsp_tready` held low 10 cycles in RESP, and RX words offered during SEND/RESP → response is held stable; `u_rx_tready` stays 0 throughout.
- `rst` asserted low while in WAIT → state IDLE, `busy`=0, `ptr`=0 asynchronously; the next request from requester 1 completes normally.
